// File: rtl/cav14_pair_checker_if.sv
// rtl/cav14_pair_checker_if.sv - sample-in / gap-out handshake bundle for cav14_pair_checker
//
// Signals:
//   in_valid, in_x, in_y   upstream sample offered (driven by master)
//   in_ready               checker can take the sample this cycle (driven by slave)
//   out_valid, out_gap,
//   out_eq                 registered result slot (driven by slave)
//   out_ready              downstream takes the slot this cycle (driven by master)
// Modports: slave = the checker, master = the environment around it.
interface cav14_pair_checker_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_gap;
  logic         out_eq;

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_gap, out_eq
  );

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_gap, out_eq
  );
endinterface

// File: rtl/cav14_pair_checker.sv
// rtl/cav14_pair_checker.sv - run-time y <= x ordering checker for the X/Y counter pair
//
// Ports:
//   clk      clock, all state on posedge
//   rst_n    synchronous active-low reset
//   bus      cav14_pair_checker_if.slave: (x, y) sample in, registered gap/eq slot out
//   err      sticky violation flag (state == ERR)
//   err_cnt  saturating count of violating transfers
//   state    FSM state: IDLE=0, TRACK=1, ERR=2
// Optional: define CAV14_STEP_CHECK_EN to also flag y steps other than +0 / +1.
module cav14_pair_checker #(
  parameter int           W       = 4,
  parameter logic [W-1:0] CNT_MAX = {W{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cav14_pair_checker_if.slave   bus,
  output logic                  err,
  output logic [W-1:0]          err_cnt,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         valid_q;
  logic [W-1:0] gap_q;
  logic         eq_q;
  logic [W-1:0] prev_y;
  logic [W-1:0] cnt_q;

  logic xfer;
  logic order_viol;
  logic step_viol;
  logic viol;

  // Slot frees up either when empty or when it is drained this very cycle.
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign xfer         = bus.in_valid && bus.in_ready;
  assign order_viol   = bus.in_y > bus.in_x;

`ifdef CAV14_STEP_CHECK_EN
  logic [W-1:0] prev_y_inc;
  assign prev_y_inc = prev_y + 1'b1;   // wraps CNT_MAX -> 0, which is a legal step
  // The first sample after reset has no predecessor, so IDLE is exempt.
  assign step_viol  = (state_q != IDLE) && (bus.in_y != prev_y) && (bus.in_y != prev_y_inc);
`else
  logic unused_prev_y;
  assign unused_prev_y = ^prev_y;
  assign step_viol     = 1'b0;
`endif

  assign viol = xfer && (order_viol || step_viol);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = viol ? ERR : TRACK;
      TRACK:   if (viol) state_d = ERR;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      gap_q   <= '0;
      eq_q    <= 1'b0;
      prev_y  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        gap_q   <= bus.in_x - bus.in_y;
        eq_q    <= (bus.in_x == bus.in_y);
        valid_q <= 1'b1;
        prev_y  <= bus.in_y;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
      if (viol && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_gap   = gap_q;
  assign bus.out_eq    = eq_q;
  assign err           = (state_q == ERR);
  assign err_cnt       = cnt_q;
  assign state         = state_q;

endmodule

// File: tb/tb_cav14_pair_checker.sv
// tb/tb_cav14_pair_checker.sv - directed table-driven bench for cav14_pair_checker
module tb_cav14_pair_checker;

`ifdef CAV14_STEP_CHECK_EN
  localparam logic STEP = 1'b1;
`else
  localparam logic STEP = 1'b0;
`endif

  typedef struct {
    logic       rst_n;
    logic       iv;
    logic [3:0] x;
    logic [3:0] y;
    logic       ordy;
    logic       ov;
    logic [3:0] gap;
    logic       eq;
    logic       err;
    logic [3:0] cnt;
    logic [1:0] st;
    logic       ir;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       err;
  logic [3:0] err_cnt;
  logic [1:0] state;

  int n_pass;
  int n_total;

  cav14_pair_checker_if #(.W(4)) bus ();

  cav14_pair_checker #(.W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err     (err),
    .err_cnt (err_cnt),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic iv, input logic [3:0] x, input logic [3:0] y,
                              input logic ordy, input logic ov, input logic [3:0] gap, input logic eq,
                              input logic e, input logic [3:0] cnt, input logic [1:0] st, input logic ir);
    vec_t v;
    v.rst_n = r;   v.iv = iv;   v.x = x;     v.y = y;     v.ordy = ordy;
    v.ov = ov;     v.gap = gap; v.eq = eq;   v.err = e;   v.cnt = cnt;
    v.st = st;     v.ir = ir;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    else
      n_pass++;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    rst_n        = v.rst_n;
    bus.in_valid = v.iv;
    bus.in_x     = v.x;
    bus.in_y     = v.y;
    bus.out_ready = v.ordy;
    @(posedge clk);
    #1;
    chk("out_valid", idx, {7'd0, bus.out_valid}, {7'd0, v.ov});
    chk("out_gap",   idx, {4'd0, bus.out_gap},   {4'd0, v.gap});
    chk("out_eq",    idx, {7'd0, bus.out_eq},    {7'd0, v.eq});
    chk("err",       idx, {7'd0, err},           {7'd0, v.err});
    chk("err_cnt",   idx, {4'd0, err_cnt},       {4'd0, v.cnt});
    chk("state",     idx, {6'd0, state},         {6'd0, v.st});
    chk("in_ready",  idx, {7'd0, bus.in_ready},  {7'd0, v.ir});
  endtask

  vec_t tab[$];

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.in_y = '0;
    bus.out_ready = 1'b1;

    //        rst iv  x     y     ordy ov gap   eq err cnt   st    ir
    tab.push_back(mk(0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 4'd0, 2'd0, 1)); // reset state
    tab.push_back(mk(1, 1, 4'h1, 4'h0, 1, 1, 4'h1, 0, 0, 4'd0, 2'd1, 1)); // first sample -> TRACK
    tab.push_back(mk(1, 1, 4'h1, 4'h1, 1, 1, 4'h0, 1, 0, 4'd0, 2'd1, 1)); // back-to-back
    tab.push_back(mk(1, 1, 4'h2, 4'h2, 1, 1, 4'h0, 1, 0, 4'd0, 2'd1, 1)); // x=2,y=2
    tab.push_back(mk(1, 0, 4'h0, 4'h0, 0, 1, 4'h0, 1, 0, 4'd0, 2'd1, 0)); // stall 1
    tab.push_back(mk(1, 1, 4'h9, 4'h9, 0, 1, 4'h0, 1, 0, 4'd0, 2'd1, 0)); // stall 2, offer refused
    tab.push_back(mk(1, 0, 4'h0, 4'h0, 0, 1, 4'h0, 1, 0, 4'd0, 2'd1, 0)); // stall 3
    tab.push_back(mk(1, 1, 4'h3, 4'h2, 1, 1, 4'h1, 0, 0, 4'd0, 2'd1, 1)); // drain+fill, no bubble
    tab.push_back(mk(1, 0, 4'h0, 4'h0, 1, 0, 4'h1, 0, 0, 4'd0, 2'd1, 1)); // drain only, data held
    tab.push_back(mk(1, 1, 4'h3, 4'h5, 1, 1, 4'hE, 0, 1, 4'd1, 2'd2, 1)); // order violation
    tab.push_back(mk(1, 1, 4'h5, 4'h5, 1, 1, 4'h0, 1, 1, 4'd1, 2'd2, 1)); // clean sample, ERR sticky
    foreach (tab[i]) run_vec(tab[i], i);

    // Saturation: 17 violating transfers starting from err_cnt=1.
    for (int i = 0; i < 17; i++) begin
      int c;
      c = (i + 2 > 15) ? 15 : i + 2;
      run_vec(mk(1, 1, 4'h0, 4'h1, 1, 1, 4'hF, 0, 1, c[3:0], 2'd2, 1), 100 + i);
    end

    // Reset mid-operation with a pending slot that is not being drained.
    run_vec(mk(1, 1, 4'h0, 4'h1, 0, 1, 4'hF, 0, 1, 4'd15, 2'd2, 0), 200);
    run_vec(mk(0, 1, 4'h7, 4'h3, 0, 0, 4'h0, 0, 0, 4'd0,  2'd0, 1), 201);

    tab.delete();
    tab.push_back(mk(1, 1, 4'hF, 4'hF, 0, 1, 4'h0, 1, 0, 4'd0, 2'd1, 0)); // x=y=MAX boundary
    tab.push_back(mk(1, 0, 4'h0, 4'h0, 1, 0, 4'h0, 1, 0, 4'd0, 2'd1, 1)); // drain
    tab.push_back(mk(0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 4'd0, 2'd0, 1)); // reset
    tab.push_back(mk(1, 1, 4'hF, 4'h0, 1, 1, 4'hF, 0, 0, 4'd0, 2'd1, 1)); // y=0
    tab.push_back(mk(1, 1, 4'hF, 4'h1, 1, 1, 4'hE, 0, 0, 4'd0, 2'd1, 1)); // y=1
    tab.push_back(mk(1, 1, 4'hF, 4'h3, 1, 1, 4'hC, 0, STEP, {3'd0, STEP}, STEP ? 2'd2 : 2'd1, 1)); // y jumps to 3
    tab.push_back(mk(0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 4'd0, 2'd0, 1)); // reset
    tab.push_back(mk(1, 1, 4'hF, 4'hE, 1, 1, 4'h1, 0, 0, 4'd0, 2'd1, 1)); // y=14
    tab.push_back(mk(1, 1, 4'hF, 4'hF, 1, 1, 4'h0, 1, 0, 4'd0, 2'd1, 1)); // y=15
    tab.push_back(mk(1, 1, 4'hF, 4'h0, 1, 1, 4'hF, 0, 0, 4'd0, 2'd1, 1)); // y wraps to 0
    tab.push_back(mk(0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 4'd0, 2'd0, 1)); // reset
    tab.push_back(mk(1, 1, 4'h0, 4'h1, 1, 1, 4'hF, 0, 1, 4'd1, 2'd2, 1)); // IDLE -> ERR, x=0,y=1
    foreach (tab[i]) run_vec(tab[i], 300 + i);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cav14_pair_checker.md
Name: cav14_pair_checker

Overview:
Downstream consumer of the two-counter (X, Y) pair stage. It accepts one (x, y) sample per valid/ready handshake and checks the ordering invariant y <= x. It forwards the gap x - y through a single registered output slot and keeps a sticky error flag and a saturating violation count. It is the run-time companion to the formal safety property on the counter stage and sits between that stage and any sink.

Parameters:
W, 4, width of x, y, gap and error counter
CNT_MAX, {W{1'b1}} (4'b1111), saturation value of err_cnt

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  synchronous reset, active low
in_valid  input  1  upstream sample valid
in_ready  output  1  block can accept a sample this cycle
in_x  input  W  X counter value
in_y  input  W  Y counter value
out_valid  output  1  output slot holds a sample
out_ready  input  1  downstream accepts the slot this cycle
out_gap  output  W  (x - y) mod 2^W of the held sample
out_eq  output  1  held sample had x == y
err  output  1  sticky: at least one violation seen since reset
err_cnt  output  W  number of violating transfers, saturating at CNT_MAX
state  output  2  FSM state: IDLE=2'd0, TRACK=2'd1, ERR=2'd2

Behaviour:
- Reset: the block has one clock and a synchronous, active-low reset (rst_n sampled on posedge clk).
- Reset values: out_valid=0, out_gap=0, out_eq=0, err=0, err_cnt=0, state=IDLE, internal prev_y=0.
- Reset mid-operation: a pending output slot is dropped with no handshake, and all state is cleared on that edge.
- Transfer: happens when in_valid && in_ready.
- in_ready is combinational: in_ready = !out_valid || out_ready.
- Latency is 1 cycle from input transfer to out_valid.
- On a transfer: out_gap <= in_x - in_y (unsigned, truncated to W), out_eq <= (in_x == in_y), out_valid <= 1, prev_y <= in_y.
- No transfer and out_ready=1: out_valid <= 0. out_gap and out_eq hold their last values.
- No transfer and out_ready=0: the slot holds; out_gap and out_eq are stable while out_valid && !out_ready.
- Simultaneous drain and fill (out_valid && out_ready && in_valid): the new sample replaces the old one and out_valid stays 1.
- Violation on a transfer: order violation when in_y > in_x (unsigned); step violation only as given under Optional Feature.
- FSM:
  - IDLE -> TRACK on the first transfer with no violation.
  - IDLE -> ERR on the first transfer with a violation.
  - TRACK -> ERR on a violating transfer.
  - ERR is sticky until reset.
  - No transfer: the state holds.
- err = (state == ERR). It is registered and rises on the edge that captures the violating sample.
- err_cnt increments by 1 on each violating transfer in any state and saturates at CNT_MAX (no wrap).
- Data keeps flowing in the ERR state; error status never back-pressures.
- Boundaries:
  - x = CNT_MAX, y = CNT_MAX: out_eq=1, out_gap=0, no violation.
  - x = 0, y = 1: violation, out_gap = CNT_MAX.

Optional Feature:
Macro CAV14_STEP_CHECK_EN.
- Defined: from TRACK or ERR, a transfer is also a violation if in_y != prev_y and in_y != prev_y + 1 (mod 2^W).
  - Wrap from CNT_MAX to 0 is legal.
  - The first sample after reset (state IDLE) is not step-checked.
- Not defined: only the order check applies; prev_y is still kept but is unused.

Test Plan:
1. Reset, then in_x=1, in_y=0, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_gap=1, out_eq=0, state=TRACK, err=0, err_cnt=0.
2. Sample x=2, y=2 accepted, then out_ready=0 for 3 cycles -> in_ready=0, out_gap=0 and out_eq=1 held. Raise out_ready with new sample x=3, y=2 -> out_gap=1 next cycle, no bubble.
3. In TRACK, in_x=3, in_y=5 -> next cycle err=1, state=ERR, err_cnt=1, out_gap=4'hE. A following x=5, y=4 -> err stays 1, err_cnt stays 1.
4. 17 consecutive violating transfers (x=0, y=1) -> err_cnt reaches 15 and holds 15. out_gap=4'hF each cycle.
5. With CAV14_STEP_CHECK_EN defined, y sequence 0, 1, 3 (x=15) -> err=1 after the third sample. y sequence 14, 15, 0 (x=15) -> err=0. With the macro undefined, the 0, 1, 3 sequence gives err=0.
6. Drive rst_n=0 for one edge while out_valid=1, err=1, err_cnt=5 -> after that edge out_valid=0, err=0, err_cnt=0, state=IDLE, in_ready=1.
